mask_encoder: RTL and testbench

MASK_ENCODER -- requirements
Module: mask_encoder

---
 rtl/mask_pkg.sv | 36 +++
 rtl/mask_record_fifo.sv | 54 +++++
 rtl/mask_encoder.sv | 243 ++++++++++++++++++++++++
 tb/tb_mask_encoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_pkg.sv
// Shared types for the mask run-length encoder.
// Record layout, run limit, byte buffer sizing and output FSM states.
package mask_pkg;

  localparam int LEN_W = 10;
  localparam int Y_W   = 10;
  localparam int X_W   = 10;
  localparam int ID_W  = 10;
  localparam int REC_W = LEN_W + Y_W + X_W + ID_W;

  localparam int ID_LSB  = 0;
  localparam int X_LSB   = ID_LSB + ID_W;
  localparam int Y_LSB   = X_LSB + X_W;
  localparam int LEN_LSB = Y_LSB + Y_W;

  localparam int MAX_RUN_LENGTH = 1023;
  localparam int REC_BYTES = REC_W / 8;
  localparam int BUF_BYTES = 6;
  localparam int BUF_W     = BUF_BYTES * 8;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [Y_W-1:0]   y;
    logic [X_W-1:0]   sx;
    logic [ID_W-1:0]  id;
  } mask_rec_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    GAP,
    FLUSH
  } mask_state_t;

endpackage

// File: rtl/mask_record_fifo.sv
// Synchronous record FIFO with a registered read port.
// data_o updates on the edge that pops; it is valid the cycle after.
module mask_record_fifo
  import mask_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  mask_rec_t              data_i,
  input  logic                   pop_i,
  output mask_rec_t              data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  mask_rec_t      mem_q [DEPTH];
  mask_rec_t      data_q;
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [CW-1:0]  cnt_q;
  logic           do_push;
  logic           do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) begin
        rd_q   <= rd_q + AW'(1);
        data_q <= mem_q[rd_q];
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign data_o  = data_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/mask_encoder.sv
// Run-length encodes segment pixels into 40-bit records and streams them as 16-bit words.
// Define MASK_ENCODER_STATS_EN to add the record_count / overflow outputs.
module mask_encoder
  import mask_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int WR_GAP     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        pixel_has_segment,
  input  logic [9:0]  pixel_segment_id,
  input  logic        frame_end,
  output logic        ioctl_wr,
  output logic [15:0] ioctl_dout,
  output logic        done
`ifdef MASK_ENCODER_STATS_EN
  ,
  output logic [14:0] record_count,
  output logic        overflow
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = $clog2(WR_GAP);

  logic            acc;
  logic            ext;
  logic            push;
  mask_rec_t       push_rec;
  logic            run_v_q, run_v_d;
  mask_rec_t       run_q, run_d;
  logic [X_W-1:0]  lx_q, lx_d;
  logic            ending_q, ending_d;
  logic            rdy_en_q;
  logic            end_ready;

  mask_rec_t       fifo_data;
  logic [CW-1:0]   fifo_cnt;
  logic            pop;

  mask_state_t     state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic            wr_q, wr_d;
  logic [15:0]     dout_q, dout_d;
  logic            done_q, done_d;

  assign pixel_ready = rdy_en_q && !ending_q &&
                       (fifo_cnt < CW'(FIFO_DEPTH - 1));
  assign acc = pixel_valid && pixel_ready;
  assign ext = run_v_q && pixel_has_segment &&
               (pixel_segment_id == run_q.id) &&
               (pixel_y == run_q.y) &&
               (pixel_x == lx_q + 10'd1) &&
               (run_q.len < LEN_W'(MAX_RUN_LENGTH));

  // Frame close is deferred one cycle so a coincident beat can still push.
  always_comb begin
    run_v_d  = run_v_q;
    run_d    = run_q;
    lx_d     = lx_q;
    push     = 1'b0;
    push_rec = run_q;
    if (ending_q) begin
      if (run_v_q) begin
        push    = 1'b1;
        run_v_d = 1'b0;
      end
    end else if (acc) begin
      if (ext) begin
        run_d.len = run_q.len + 10'd1;
        lx_d      = pixel_x;
        if (run_q.len == LEN_W'(MAX_RUN_LENGTH - 1)) begin
          push     = 1'b1;
          push_rec = run_d;
          run_v_d  = 1'b0;
        end
      end else begin
        push    = run_v_q;
        run_v_d = pixel_has_segment;
        run_d   = '{len: 10'd1, y: pixel_y,
                    sx: pixel_x, id: pixel_segment_id};
        lx_d    = pixel_x;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_v_q  <= 1'b0;
      run_q    <= '0;
      lx_q     <= '0;
      ending_q <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      run_v_q  <= run_v_d;
      run_q    <= run_d;
      lx_q     <= lx_d;
      ending_q <= ending_d;
      rdy_en_q <= 1'b1;
    end
  end

  mask_record_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .data_i  (push_rec),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .count_o (fifo_cnt)
  );

  assign end_ready = (ending_q || frame_end) && !run_v_d && !push &&
                     (fifo_cnt == '0) && (bcnt_q < 3'd2);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bcnt_q >= 3'd2) begin
          state_d = EMIT;
        end else if (fifo_cnt != '0) begin
          state_d = LOAD;
          pop     = 1'b1;
        end else if (end_ready) begin
          state_d = FLUSH;
        end
      end
      LOAD: state_d = IDLE;
      EMIT: begin
        state_d = GAP;
        gap_d   = '0;
      end
      GAP: begin
        if (gap_q == GW'(WR_GAP - 2)) state_d = IDLE;
        else gap_d = gap_q + GW'(1);
      end
      FLUSH: begin
        state_d = (bcnt_q != 3'd0) ? GAP : IDLE;
        gap_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte buffer drains from the low end; LOAD appends above what is left.
  always_comb begin
    buf_d    = buf_q;
    bcnt_d   = bcnt_q;
    wr_d     = 1'b0;
    dout_d   = dout_q;
    done_d   = 1'b0;
    ending_d = ending_q || frame_end;
    unique case (state_q)
      LOAD: begin
        if (bcnt_q == 3'd0) buf_d = {8'h00, fifo_data};
        else buf_d = {fifo_data, buf_q[7:0]};
        bcnt_d = bcnt_q + 3'(REC_BYTES);
      end
      EMIT: begin
        wr_d   = 1'b1;
        dout_d = buf_q[15:0];
        buf_d  = {16'h0000, buf_q[BUF_W-1:16]};
        bcnt_d = bcnt_q - 3'd2;
      end
      FLUSH: begin
        if (bcnt_q != 3'd0) begin
          wr_d   = 1'b1;
          dout_d = {8'h00, buf_q[7:0]};
          buf_d  = '0;
          bcnt_d = 3'd0;
        end else begin
          done_d   = 1'b1;
          ending_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_q  <= '0;
      bcnt_q <= '0;
      wr_q   <= 1'b0;
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      bcnt_q <= bcnt_d;
      wr_q   <= wr_d;
      dout_q <= dout_d;
      done_q <= done_d;
    end
  end

  assign ioctl_wr   = wr_q;
  assign ioctl_dout = dout_q;
  assign done       = done_q;

`ifdef MASK_ENCODER_STATS_EN
  logic [14:0] rc_q;
  logic        ov_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rc_q <= '0;
      ov_q <= 1'b0;
    end else if (done_q) begin
      rc_q <= '0;
    end else if (push) begin
      if (rc_q != 15'h7fff) rc_q <= rc_q + 15'd1;
      else ov_q <= 1'b1;
    end
  end

  assign record_count = rc_q;
  assign overflow     = ov_q;
`endif

endmodule

// File: tb/tb_mask_encoder.sv
// Directed bench for mask_encoder with a word scoreboard.
// Expected bytes are built from hand-derived records; a monitor collects strobes.
module tb_mask_encoder;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  logic        clk;
  logic        reset_n;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_has_segment;
  logic [9:0]  pixel_segment_id;
  logic        frame_end;
  logic        ioctl_wr;
  logic [15:0] ioctl_dout;
  logic        done;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int gap_viol = 0;
  int stalls   = 0;
  int mcyc     = 0;
  int last_wr  = -1000;

  logic [15:0] obs_q [$];
  logic [15:0] exp_q [$];
  logic [7:0]  byte_q [$];

  mask_encoder #(
    .FIFO_DEPTH (DEPTH),
    .WR_GAP     (GAP)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pixel_valid       (pixel_valid),
    .pixel_ready       (pixel_ready),
    .pixel_x           (pixel_x),
    .pixel_y           (pixel_y),
    .pixel_has_segment (pixel_has_segment),
    .pixel_segment_id  (pixel_segment_id),
    .frame_end         (frame_end),
    .ioctl_wr          (ioctl_wr),
    .ioctl_dout        (ioctl_dout),
    .done              (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    forever begin
      @(negedge clk);
      mcyc++;
      if (ioctl_wr === 1'b1) begin
        obs_q.push_back(ioctl_dout);
        if (mcyc - last_wr < GAP) gap_viol++;
        last_wr = mcyc;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_record(input int len, input int y,
                            input int sx, input int id);
    logic [39:0] r;
    logic [15:0] w;
    r = {10'(len), 10'(y), 10'(sx), 10'(id)};
    for (int b = 0; b < 5; b++) byte_q.push_back(r[8*b +: 8]);
    while (byte_q.size() >= 2) begin
      w = {byte_q[1], byte_q[0]};
      void'(byte_q.pop_front());
      void'(byte_q.pop_front());
      exp_q.push_back(w);
    end
  endtask

  task automatic exp_end();
    if (byte_q.size() == 1) exp_q.push_back({8'h00, byte_q[0]});
    byte_q.delete();
  endtask

  task automatic beat(input int x, input int y, input bit has,
                      input int id, input bit fe);
    int n;
    pixel_x           = 10'(x);
    pixel_y           = 10'(y);
    pixel_has_segment = has;
    pixel_segment_id  = 10'(id);
    pixel_valid       = 1'b1;
    n = 0;
    while (!pixel_ready && n < 200) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (n >= 200) chk("ready_timeout", {31'd0, pixel_ready}, 32'd1);
    frame_end = fe;
    @(negedge clk);
    pixel_valid = 1'b0;
    frame_end   = 1'b0;
  endtask

  task automatic fe_pulse(input string tag);
    pixel_valid = 1'b0;
    frame_end   = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    chk({tag, "_rdy_low"}, {31'd0, pixel_ready}, 32'd0);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt - d0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_frame(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), {16'd0, obs_q[i]},
          {16'd0, exp_q[i]});
    obs_q.delete();
    exp_q.delete();
    byte_q.delete();
  endtask

  task automatic run_t1(input string tag);
    int d0;
    d0 = done_cnt;
    for (int x = 10; x <= 13; x++) beat(x, 3, 1'b1, 5, 1'b0);
    fe_pulse(tag);
    exp_q.push_back(16'h2805);
    exp_q.push_back(16'h0030);
    exp_q.push_back(16'h0001);
    wait_done(d0, tag);
    compare_frame(tag);
  endtask

  initial begin
    int d0;
    int nobs;
    reset_n           = 1'b0;
    pixel_valid       = 1'b0;
    pixel_x           = '0;
    pixel_y           = '0;
    pixel_has_segment = 1'b0;
    pixel_segment_id  = '0;
    frame_end         = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr", {31'd0, ioctl_wr}, 32'd0);
    chk("rst_dout", {16'd0, ioctl_dout}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdy", {31'd0, pixel_ready}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rdy_rise", {31'd0, pixel_ready}, 32'd1);

    run_t1("t1");

    d0 = done_cnt;
    for (int x = 0; x < 20; x++) beat(x, 5, 1'b1, 7, 1'b0);
    for (int x = 20; x < 30; x++) beat(x, 5, 1'b1, 8, x == 29);
    chk("t2_rdy_low", {31'd0, pixel_ready}, 32'd0);
    exp_record(20, 5, 0, 7);
    exp_record(10, 5, 20, 8);
    exp_end();
    wait_done(d0, "t2");
    compare_frame("t2");

    d0 = done_cnt;
    for (int x = 0; x < 5; x++) beat(x, 2, 1'b0, 9, 1'b0);
    pixel_valid = 1'b0;
    frame_end   = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    chk("t3_done_early", {31'd0, done}, 32'd0);
    chk("t3_rdy_low", {31'd0, pixel_ready}, 32'd0);
    @(negedge clk);
    chk("t3_done_at2", {31'd0, done}, 32'd1);
    repeat (20) @(negedge clk);
    chk("t3_no_words", obs_q.size(), 32'd0);
    chk("t3_one_done", done_cnt - d0, 32'd1);
    obs_q.delete();

    d0 = done_cnt;
    for (int i = 0; i < 1100; i++) beat(i % 1024, 0, 1'b1, 7, i == 1099);
    exp_record(1023, 0, 0, 7);
    exp_record(77, 0, 1023, 7);
    exp_end();
    wait_done(d0, "t4");
    compare_frame("t4");

    d0 = done_cnt;
    stalls = 0;
    for (int k = 0; k < 20; k++) beat(2 * k, 9, 1'b1, k + 1, 1'b0);
    fe_pulse("t5");
    for (int k = 0; k < 20; k++) exp_record(1, 9, 2 * k, k + 1);
    exp_end();
    chk("t5_stall_seen", {31'd0, stalls > 0}, 32'd1);
    wait_done(d0, "t5");
    compare_frame("t5");

    d0 = done_cnt;
    for (int x = 0; x < 6; x++) beat(x, 1, 1'b1, 3, x == 5);
    nobs = 0;
    while (obs_q.size() == 0 && nobs < 200) begin
      @(negedge clk);
      nobs++;
    end
    chk("t6_first_wr", {31'd0, obs_q.size() > 0}, 32'd1);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_rst_wr", {31'd0, ioctl_wr}, 32'd0);
    chk("t6_rst_dout", {16'd0, ioctl_dout}, 32'd0);
    chk("t6_rst_rdy", {31'd0, pixel_ready}, 32'd0);
    nobs = obs_q.size();
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_no_more_wr", obs_q.size(), nobs);
    chk("t6_no_done", done_cnt - d0, 32'd0);
    obs_q.delete();
    exp_q.delete();
    byte_q.delete();

    run_t1("t6_clean");

    chk("wr_gap", gap_viol, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
